// File: rtl/syn_md_sel_if.sv
// -----------------------------------------------------------------------------
// syn_md_sel_if
// Mode-request handshake between the DSP-side register interface and the
// sync-mode switch sequencer.
//   req_valid : request strobe (master -> slave)
//   req_mode  : requested mode, 0 idle, 1 RT/sw1, 2 RT/sw2, 3 soft
//   req_ready : sequencer can accept a request (slave -> master)
// A transfer happens on a clock edge where req_valid and req_ready are both 1.
// -----------------------------------------------------------------------------
interface syn_md_sel_if;
    logic       req_valid;
    logic [1:0] req_mode;
    logic       req_ready;

    modport master (
        output req_valid,
        output req_mode,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_mode,
        output req_ready
    );
endinterface

// File: rtl/syn_md_sel.sv
// -----------------------------------------------------------------------------
// syn_md_sel
// Sync-mode switch sequencer for the soft_d / rt_sw / sw1 / sw2 select lines
// consumed by syn_md_combine. Every mode change is break-before-make: all
// selects go low for DEAD_CYC clocks, the new pattern is then driven and
// held for HOLD_CYC clocks before another request is accepted.
//
// Parameters
//   DEAD_CYC : break interval in clocks (1..65535)
//   HOLD_CYC : minimum hold of a new pattern in clocks (1..65535)
// Ports
//   sysclk   : system clock (100 MHz)
//   sysrst   : synchronous active-high reset
//   req      : mode-request handshake (slave side of syn_md_sel_if)
//   md_done  : one-cycle pulse when a pattern completes its hold, or one
//              cycle after a same-mode request
//   md_cur   : mode applied; during the break it already shows the target
//   soft_d   : soft-drive select
//   rt_sw    : real-time switch select
//   sw1      : path-1 select
//   sw2      : path-2 select
//   drop_cnt : (only with SYN_MD_DROP_CNT_EN) saturating count of requests
//              presented while req_ready was low
//
// Optional feature macro: SYN_MD_DROP_CNT_EN
// All outputs come straight from flops; there is no combinational path from
// the request inputs to any select line.
// -----------------------------------------------------------------------------
module syn_md_sel #(
    parameter int unsigned DEAD_CYC = 20,
    parameter int unsigned HOLD_CYC = 100
) (
    input  logic        sysclk,
    input  logic        sysrst,
    syn_md_sel_if.slave req,
    output logic        md_done,
    output logic [1:0]  md_cur,
    output logic        soft_d,
    output logic        rt_sw,
    output logic        sw1,
    output logic        sw2
`ifdef SYN_MD_DROP_CNT_EN
    ,
    output logic [7:0]  drop_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_STABLE = 2'd0,
        ST_BREAK  = 2'd1,
        ST_MAKE   = 2'd2
    } state_t;

    // The counter counts from 0, so the last cycle of a phase is N-1.
    localparam logic [15:0] DEAD_LAST = 16'(DEAD_CYC - 32'd1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYC - 32'd1);

    // Select pattern packed as {soft_d, rt_sw, sw1, sw2}. sw1 and sw2 are
    // never set together by any mode, which keeps the two paths exclusive.
    function automatic logic [3:0] sel_decode(input logic [1:0] mode);
        logic [3:0] sel;
        case (mode)
            2'd0:    sel = 4'b0000;
            2'd1:    sel = 4'b0110;
            2'd2:    sel = 4'b0101;
            2'd3:    sel = 4'b1000;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_s;
    logic [1:0]  md_cur_r;
    logic [1:0]  md_cur_s;
    logic [3:0]  sel_r;
    logic [3:0]  sel_s;
    logic        ready_r;
    logic        ready_s;
    logic        done_r;
    logic        done_s;
    logic        accept_s;

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so that every output can be taken directly from a register.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        md_cur_s = md_cur_r;
        sel_s    = sel_r;
        ready_s  = ready_r;
        done_s   = 1'b0;
        accept_s = req.req_valid && ready_r;

        case (state_r)
            ST_STABLE: begin
                sel_s   = sel_decode(md_cur_r);
                ready_s = 1'b1;
                if (accept_s) begin
                    if (req.req_mode != md_cur_r) begin
                        // Start the break: selects drop immediately, md_cur
                        // already reports the target.
                        state_s  = ST_BREAK;
                        md_cur_s = req.req_mode;
                        cnt_s    = 16'd0;
                        sel_s    = 4'b0000;
                        ready_s  = 1'b0;
                    end else begin
                        // Same-mode request: acknowledged, pattern untouched.
                        done_s = 1'b1;
                    end
                end else begin
                    cnt_s = 16'd0;
                end
            end

            ST_BREAK: begin
                ready_s = 1'b0;
                if (cnt_r == DEAD_LAST) begin
                    state_s = ST_MAKE;
                    cnt_s   = 16'd0;
                    sel_s   = sel_decode(md_cur_r);
                end else begin
                    cnt_s = cnt_r + 16'd1;
                    sel_s = 4'b0000;
                end
            end

            ST_MAKE: begin
                sel_s = sel_decode(md_cur_r);
                if (cnt_r == HOLD_LAST) begin
                    state_s = ST_STABLE;
                    cnt_s   = 16'd0;
                    ready_s = 1'b1;
                    done_s  = 1'b1;
                end else begin
                    cnt_s   = cnt_r + 16'd1;
                    ready_s = 1'b0;
                end
            end

            default: begin
                // Unreachable encoding: fall back to a safe idle pattern.
                state_s  = ST_STABLE;
                cnt_s    = 16'd0;
                md_cur_s = 2'd0;
                sel_s    = 4'b0000;
                ready_s  = 1'b1;
            end
        endcase
    end

    // Sequencer state, counter and registered outputs.
    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            state_r  <= ST_STABLE;
            cnt_r    <= 16'd0;
            md_cur_r <= 2'd0;
            sel_r    <= 4'b0000;
            ready_r  <= 1'b1;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            md_cur_r <= md_cur_s;
            sel_r    <= sel_s;
            ready_r  <= ready_s;
            done_r   <= done_s;
        end
    end

`ifdef SYN_MD_DROP_CNT_EN
    logic [7:0] drop_cnt_r;

    // Count requests presented while busy; holds at 255 instead of wrapping.
    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            drop_cnt_r <= 8'd0;
        end else if (req.req_valid && !ready_r && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign drop_cnt = drop_cnt_r;
`endif

    assign req.req_ready = ready_r;
    assign md_done       = done_r;
    assign md_cur        = md_cur_r;
    assign soft_d        = sel_r[3];
    assign rt_sw         = sel_r[2];
    assign sw1           = sel_r[1];
    assign sw2           = sel_r[0];

endmodule

// File: tb/tb_syn_md_sel.sv
// -----------------------------------------------------------------------------
// tb_syn_md_sel
// Directed bench for syn_md_sel with DEAD_CYC=4, HOLD_CYC=8. A request
// presented after edge 0 is taken at edge 1: selects are 0 at edges 1..4,
// the new pattern shows from edge 5, req_ready/md_done return at edge 13.
// Select vectors below are written as {soft_d, rt_sw, sw1, sw2}.
// -----------------------------------------------------------------------------
module tb_syn_md_sel;

    localparam int unsigned DEAD = 4;
    localparam int unsigned HOLD = 8;

    logic       sysclk;
    logic       sysrst;
    logic       md_done;
    logic [1:0] md_cur;
    logic       soft_d;
    logic       rt_sw;
    logic       sw1;
    logic       sw2;
`ifdef SYN_MD_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;

    syn_md_sel_if rif ();

    syn_md_sel #(
        .DEAD_CYC (DEAD),
        .HOLD_CYC (HOLD)
    ) dut (
        .sysclk   (sysclk),
        .sysrst   (sysrst),
        .req      (rif),
        .md_done  (md_done),
        .md_cur   (md_cur),
        .soft_d   (soft_d),
        .rt_sw    (rt_sw),
        .sw1      (sw1),
        .sw2      (sw2)
`ifdef SYN_MD_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Path exclusivity is checked on every cycle once reset has been applied.
    bit excl_on = 1'b0;
    always @(negedge sysclk) begin
        if (excl_on) begin
            n_checks++;
            assert (!(sw1 === 1'b1 && sw2 === 1'b1)) else begin
                n_err++;
                $error("FAIL sw_excl: observed sw1=%b sw2=%b expected not both 1", sw1, sw2);
            end
        end
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Full change to 'mode'; optional busy requests (mode 0) at edges 3 and 7.
    task automatic run_change(input logic [1:0] mode, input logic [3:0] pat, input bit drops);
        rif.req_valid = 1'b1;
        rif.req_mode  = mode;
        for (int e = 1; e <= 13; e++) begin
            tick();
            rif.req_valid = drops && (e == 3 || e == 7);
            rif.req_mode  = (drops && (e == 3 || e == 7)) ? 2'd0 : mode;
            chk("chg_sel",   {soft_d, rt_sw, sw1, sw2}, (e <= 4) ? 4'b0000 : pat);
            chk("chg_ready", rif.req_ready, (e == 13) ? 1'b1 : 1'b0);
            chk("chg_done",  md_done,       (e == 13) ? 1'b1 : 1'b0);
            chk("chg_cur",   md_cur,        mode);
        end
        rif.req_valid = 1'b0;
    endtask

    initial begin
        rif.req_valid = 1'b0;
        rif.req_mode  = 2'd0;
        sysrst        = 1'b1;

        // Reset state
        tick();
        tick();
        excl_on = 1'b1;
        chk("rst_sel",   {soft_d, rt_sw, sw1, sw2}, 4'b0000);
        chk("rst_cur",   md_cur, 2'd0);
        chk("rst_ready", rif.req_ready, 1'b1);
        chk("rst_done",  md_done, 1'b0);
`ifdef SYN_MD_DROP_CNT_EN
        chk("rst_drop",  drop_cnt, 8'd0);
`endif
        sysrst = 1'b0;
        tick();

        // Mode 0 -> 1
        run_change(2'd1, 4'b0110, 1'b0);
        // Back-to-back while md_done is high: mode 1 -> 2
        run_change(2'd2, 4'b0101, 1'b0);

        // Same-mode request: immediate md_done, ready stays high
        rif.req_valid = 1'b1;
        rif.req_mode  = 2'd2;
        tick();
        rif.req_valid = 1'b0;
        chk("same_done",  md_done, 1'b1);
        chk("same_ready", rif.req_ready, 1'b1);
        chk("same_sel",   {soft_d, rt_sw, sw1, sw2}, 4'b0101);
        chk("same_cur",   md_cur, 2'd2);
        tick();
        chk("same_done2", md_done, 1'b0);

        // Mode 2 -> 3 with two requests dropped while busy
        run_change(2'd3, 4'b1000, 1'b1);
        chk("drop_cur", md_cur, 2'd3);
`ifdef SYN_MD_DROP_CNT_EN
        chk("drop_cnt2", drop_cnt, 8'd2);
`endif
        tick();

        // Mode 3 -> 1, reset during MAKE
        rif.req_valid = 1'b1;
        rif.req_mode  = 2'd1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            rif.req_valid = 1'b0;
        end
        chk("mk_sel",   {soft_d, rt_sw, sw1, sw2}, 4'b0110);
        chk("mk_ready", rif.req_ready, 1'b0);
        sysrst = 1'b1;
        tick();
        sysrst = 1'b0;
        chk("mrst_sel",   {soft_d, rt_sw, sw1, sw2}, 4'b0000);
        chk("mrst_cur",   md_cur, 2'd0);
        chk("mrst_ready", rif.req_ready, 1'b1);
        chk("mrst_done",  md_done, 1'b0);
`ifdef SYN_MD_DROP_CNT_EN
        chk("mrst_drop",  drop_cnt, 8'd0);

        // Saturation: valid held high, 12 drops per change, 30 changes
        for (int k = 0; k < 30; k++) begin
            rif.req_valid = 1'b1;
            rif.req_mode  = (k % 2 == 0) ? 2'd1 : 2'd2;
            for (int e = 0; e < 13; e++) begin
                tick();
            end
            if (k == 0) begin
                chk("sat_first", drop_cnt, 8'd12);
            end
        end
        rif.req_valid = 1'b0;
        tick();
        chk("sat_255", drop_cnt, 8'd255);
`endif
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
